// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB master bridge: each accepted AHB transfer becomes one APB SETUP+ACCESS.
// Define AHB2APB_PSLVERR_EN to turn PSLVERR from the selected slave into a 2-cycle AHB ERROR.
package ahb_params_pkg;
  localparam logic [1:0] HTRANS_IDLE     = 2'b00;
  localparam logic [1:0] HTRANS_BUSY     = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ   = 2'b10;
  localparam logic [1:0] HTRANS_SEQ      = 2'b11;
  localparam logic [2:0] HSIZE_BYTE      = 3'b000;
  localparam logic [2:0] HSIZE_HALF_WORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD      = 3'b010;
endpackage

module ahb2apb_bridge
  import ahb_params_pkg::*;
#(
  parameter int ADDR_WIDTH        = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int NO_OF_APB_SLAVES  = 3,
  parameter int APB_SLV_ADDR_BITS = 12
) (
  input  logic                                   HCLK,
  input  logic                                   HRESET,
  input  logic                                   HSEL,
  input  logic [ADDR_WIDTH-1:0]                  HADDR,
  input  logic [1:0]                             HTRANS,
  input  logic                                   HWRITE,
  input  logic [2:0]                             HSIZE,
  input  logic [DATA_WIDTH-1:0]                  HWDATA,
  input  logic                                   HREADY,
  output logic                                   HREADYOUT,
  output logic                                   HRESP,
  output logic [DATA_WIDTH-1:0]                  HRDATA,
  output logic [ADDR_WIDTH-1:0]                  PADDR,
  output logic [NO_OF_APB_SLAVES-1:0]            PSEL,
  output logic                                   PENABLE,
  output logic                                   PWRITE,
  output logic [DATA_WIDTH-1:0]                  PWDATA,
  input  logic [NO_OF_APB_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NO_OF_APB_SLAVES-1:0]            PREADY,
  input  logic [NO_OF_APB_SLAVES-1:0]            PSLVERR
);

  localparam int IDX_W = 4;

  typedef enum logic [2:0] {ST_IDLE, ST_WDATA, ST_SETUP, ST_ACCESS, ST_ERR} state_t;

  state_t                        state, state_n;
  logic [IDX_W-1:0]              idx, idx_n, addr_idx;
  logic                          hreadyout_n, hresp_n, penable_n, pwrite_n;
  logic [DATA_WIDTH-1:0]         hrdata_n, pwdata_n, sel_rdata;
  logic [ADDR_WIDTH-1:0]         paddr_n;
  logic [NO_OF_APB_SLAVES-1:0]   psel_n, addr_onehot, idx_onehot;
  logic                          accept, bad_access, sel_ready, sel_err, slverr_hit;

  assign addr_idx   = HADDR[APB_SLV_ADDR_BITS +: IDX_W];
  assign accept     = HSEL && HREADY && (state == ST_IDLE) &&
                      ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  // One extra bit so that NO_OF_APB_SLAVES = 16 does not wrap to zero.
  assign bad_access = ({1'b0, addr_idx} >= (IDX_W+1)'(NO_OF_APB_SLAVES)) || (HSIZE > HSIZE_WORD);

  // Slave decode for the incoming address and response mux for the latched slave.
  always_comb begin
    addr_onehot = '0;
    idx_onehot  = '0;
    sel_ready   = 1'b0;
    sel_err     = 1'b0;
    sel_rdata   = '0;
    for (int i = 0; i < NO_OF_APB_SLAVES; i++) begin
      if (addr_idx == IDX_W'(i)) addr_onehot[i] = 1'b1;
      if (idx == IDX_W'(i)) begin
        idx_onehot[i] = 1'b1;
        sel_ready     = PREADY[i];
        sel_err       = PSLVERR[i];
        sel_rdata     = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef AHB2APB_PSLVERR_EN
  assign slverr_hit = sel_err;
`else
  logic unused_sel_err;
  assign unused_sel_err = sel_err;
  assign slverr_hit     = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    hreadyout_n = HREADYOUT;
    hresp_n     = HRESP;
    hrdata_n    = HRDATA;
    paddr_n     = PADDR;
    psel_n      = PSEL;
    penable_n   = PENABLE;
    pwrite_n    = PWRITE;
    pwdata_n    = PWDATA;
    unique case (state)
      ST_IDLE: begin
        // Also the second cycle of an error response: HRESP drops here unless a new error starts.
        hreadyout_n = 1'b1;
        hresp_n     = 1'b0;
        if (accept) begin
          hreadyout_n = 1'b0;
          if (bad_access) begin
            hresp_n = 1'b1;
            state_n = ST_ERR;
          end else begin
            idx_n    = addr_idx;
            paddr_n  = HADDR;
            pwrite_n = HWRITE;
            if (HWRITE) begin
              state_n = ST_WDATA;
            end else begin
              psel_n  = addr_onehot;
              state_n = ST_SETUP;
            end
          end
        end
      end
      ST_WDATA: begin
        pwdata_n = HWDATA;
        psel_n   = idx_onehot;
        state_n  = ST_SETUP;
      end
      ST_SETUP: begin
        penable_n = 1'b1;
        state_n   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (sel_ready) begin
          psel_n    = '0;
          penable_n = 1'b0;
          if (slverr_hit) begin
            hresp_n = 1'b1;
            state_n = ST_ERR;
          end else begin
            if (!PWRITE) hrdata_n = sel_rdata;
            hreadyout_n = 1'b1;
            state_n     = ST_IDLE;
          end
        end
      end
      ST_ERR: begin
        hreadyout_n = 1'b1;
        hresp_n     = 1'b1;
        state_n     = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      idx       <= '0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= '0;
      PADDR     <= '0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      HREADYOUT <= hreadyout_n;
      HRESP     <= hresp_n;
      HRDATA    <= hrdata_n;
      PADDR     <= paddr_n;
      PSEL      <= psel_n;
      PENABLE   <= penable_n;
      PWRITE    <= pwrite_n;
      PWDATA    <= pwdata_n;
    end
  end

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Randomized bench for ahb2apb_bridge: AHB master driver, APB slave memories and a transfer-level model.
module tb_ahb2apb_bridge;
  import ahb_params_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET, HSEL, HWRITE, HREADY;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HREADYOUT, HRESP, PENABLE, PWRITE;
  logic [31:0] HRDATA, PADDR, PWDATA;
  logic [2:0]  PSEL, PREADY, PSLVERR;
  logic [95:0] PRDATA;

  ahb2apb_bridge dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .PADDR(PADDR),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] slv_mem [3][16];
  logic [31:0] ref_mem [3][16];
  logic [31:0] last_rd;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic drive_prdata();
    for (int i = 0; i < 3; i++) PRDATA[i*32 +: 32] = slv_mem[i][PADDR[5:2]];
  endtask

  // One AHB transfer presented now (at a negedge); returns at the negedge where HREADYOUT=1.
  task automatic xfer(input logic [31:0] addr, input bit wr, input logic [2:0] size,
                      input logic [31:0] wdata, input logic [1:0] trans,
                      input int waits, input bit slverr);
    int          sidx, word, ncyc, nsetup, nacc, exp_cyc;
    bit          bad, apb_err, done, seen, rdy, prev_hresp;
    logic [98:0] saved;
    sidx = int'(addr[15:12]);
    word = int'(addr[5:2]);
    bad  = (sidx >= 3) || (size > HSIZE_WORD);
`ifdef AHB2APB_PSLVERR_EN
    apb_err = !bad && slverr;
`else
    apb_err = 1'b0;
`endif
    HSEL = 1'b1; HREADY = 1'b1; HTRANS = trans; HADDR = addr;
    HWRITE = wr; HSIZE = size; HWDATA = ~wdata;
    ncyc = 0; nsetup = 0; nacc = 0; done = 0; seen = 0; prev_hresp = 0; saved = '0;
    while (!done && ncyc < 40) begin
      @(negedge HCLK);
      ncyc++;
      if (PSEL != 3'b000) begin
        check_eq("psel_onehot", 64'($onehot(PSEL)), 64'd1);
        if (!seen) begin
          seen  = 1;
          saved = {PSEL, PADDR, PWRITE, PWDATA, PENABLE, 1'b0};
          check_eq("psel", PSEL, 64'(3'b001 << sidx));
          check_eq("paddr", PADDR, addr);
          check_eq("pwrite", PWRITE, wr);
          if (wr) check_eq("pwdata", PWDATA, wdata);
        end else begin
          check_eq("p_stable", {PSEL, PADDR, PWRITE, PWDATA}, saved[98:2]);
        end
        if (!PENABLE) nsetup++; else nacc++;
      end
      if (HREADYOUT) done = 1;
      else begin
        if (bad) check_eq("hresp_err_c1", HRESP, 1);
        else if (!apb_err) check_eq("hresp_wait", HRESP, 0);
        prev_hresp = HRESP;
      end
      // APB slave side
      for (int i = 0; i < 3; i++) begin
        if (PSEL[i] && PENABLE) begin
          rdy        = (nacc - 1 >= waits);
          PREADY[i]  = rdy;
          PSLVERR[i] = rdy ? slverr : 1'($urandom);
          if (rdy && PWRITE && !slverr) slv_mem[i][PADDR[5:2]] = PWDATA;
        end else begin
          PREADY[i]  = 1'($urandom);
          PSLVERR[i] = 1'($urandom);
        end
      end
      drive_prdata();
      if (ncyc == 1) begin
        HTRANS = HTRANS_IDLE; HSEL = 1'($urandom); HADDR = $urandom; HWDATA = wdata;
      end
    end
    check_eq("no_timeout", done, 1);
    exp_cyc = bad ? 2 : ((wr ? 4 : 3) + waits + (apb_err ? 1 : 0));
    check_eq("latency", ncyc, exp_cyc);
    check_eq("setup_cycles", nsetup, bad ? 0 : 1);
    check_eq("access_cycles", nacc, bad ? 0 : waits + 1);
    check_eq("hresp_end", HRESP, bad || apb_err);
    if (bad || apb_err) check_eq("hresp_c1", prev_hresp, 1);
    check_eq("psel_end", {PSEL, PENABLE}, 0);
    if (!bad && !apb_err && !wr) last_rd = ref_mem[sidx][word];
    if (!bad && wr && !slverr) ref_mem[sidx][word] = wdata;
    check_eq("hrdata", HRDATA, last_rd);
  endtask

  // Transfers that must be ignored: IDLE/BUSY, not selected, or bus not ready.
  task automatic noop(input int kind);
    HSEL = 1'b1; HREADY = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = $urandom; HWRITE = 1'($urandom);
    HSIZE = HSIZE_WORD;
    case (kind)
      0: HTRANS = HTRANS_IDLE;
      1: HTRANS = HTRANS_BUSY;
      2: HSEL = 1'b0;
      default: HREADY = 1'b0;
    endcase
    @(negedge HCLK);
    check_eq("noop_ready", HREADYOUT, 1);
    check_eq("noop_hresp", HRESP, 0);
    check_eq("noop_psel", {PSEL, PENABLE}, 0);
    check_eq("noop_hrdata", HRDATA, last_rd);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, addr;
    logic [3:0]  sidx4;
    logic [2:0]  sz;
    for (int s = 0; s < 3; s++)
      for (int w = 0; w < 16; w++) begin
        slv_mem[s][w] = $urandom;
        ref_mem[s][w] = slv_mem[s][w];
      end
    slv_mem[2][1] = 32'h1234_5678;
    ref_mem[2][1] = 32'h1234_5678;
    HRESET = 1'b1; HSEL = 0; HADDR = 0; HTRANS = HTRANS_IDLE; HWRITE = 0; HSIZE = HSIZE_WORD;
    HWDATA = 0; HREADY = 1; PREADY = 0; PSLVERR = 0; PRDATA = '0;
    last_rd = 32'h0;
    repeat (2) @(negedge HCLK);
    check_eq("rst_ready", HREADYOUT, 1);
    check_eq("rst_hresp", HRESP, 0);
    check_eq("rst_hrdata", HRDATA, 0);
    check_eq("rst_apb", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 0);
    HRESET = 1'b0;
    drive_prdata();

    // Directed cases
    xfer(32'h0000_1000, 1, HSIZE_WORD, 32'hDEAD_BEEF, HTRANS_NONSEQ, 0, 0);
    xfer(32'h0000_2004, 0, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 3, 0);
    check_eq("read_2004", HRDATA, 32'h1234_5678);
    xfer(32'h0000_3000, 1, HSIZE_WORD, 32'hCAFE_F00D, HTRANS_NONSEQ, 0, 0);
    xfer(32'h0000_1010, 0, 3'b011, 32'h0, HTRANS_NONSEQ, 0, 0);
    xfer(32'h0000_0000, 0, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 0, 1);
    xfer(32'h0000_0000, 1, HSIZE_WORD, 32'hA5A5_0001, HTRANS_NONSEQ, 0, 0);
    xfer(32'h0000_0004, 0, HSIZE_WORD, 32'h0, HTRANS_SEQ, 0, 0);
    xfer(32'h0000_0000, 0, HSIZE_BYTE, 32'h0, HTRANS_NONSEQ, 1, 0);
    check_eq("readback_0000", HRDATA, 32'hA5A5_0001);
    for (int k = 0; k < 4; k++) noop(k);

    // Reset while a read is stalled in ACCESS
    HSEL = 1; HREADY = 1; HTRANS = HTRANS_NONSEQ; HADDR = 32'h0000_0008; HWRITE = 0; HSIZE = HSIZE_WORD;
    PREADY = 3'b000;
    @(negedge HCLK);
    HTRANS = HTRANS_IDLE;
    @(negedge HCLK);
    check_eq("stall_penable", PENABLE, 1);
    HRESET = 1'b1;
    @(negedge HCLK);
    check_eq("midrst_apb", {PSEL, PENABLE}, 0);
    check_eq("midrst_ready", HREADYOUT, 1);
    check_eq("midrst_hresp", HRESP, 0);
    HRESET = 1'b0;
    last_rd = 32'h0;

    // Randomized traffic, all back-to-back
    for (int n = 0; n < 200; n++) begin
      r = $urandom;
      if (r[3:0] == 4'd0) begin
        noop(int'(r[5:4]));
      end else begin
        sidx4 = (r[7:4] == 4'd0) ? 4'($urandom_range(3, 15)) : 4'($urandom_range(0, 2));
        sz    = (r[10:8] == 3'd0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        addr  = $urandom;
        addr[15:12] = sidx4;
        xfer(addr, r[11], sz, $urandom, r[12] ? HTRANS_SEQ : HTRANS_NONSEQ,
             int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
